// File: rtl/aui_am_lock.sv
// aui_am_lock: per-flow alignment-marker lock and two-flow deskew for the 1.6T AUI receive path.
// Optional feature macro AUI_AM_STRIP_EN: when defined, AM pairs are dropped from the output stream.

module aui_am_lock_fsm #(
  parameter int                  AM_WIDTH     = 64,
  parameter logic [AM_WIDTH-1:0] AM_VALUE     = '0,
  parameter int                  AM_PERIOD    = 1024,
  parameter int                  LOCK_COUNT   = 2,
  parameter int                  UNLOCK_COUNT = 3,
  parameter int                  PW           = $clog2(AM_PERIOD)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic [AM_WIDTH-1:0] am_field,
  output logic [PW-1:0]       pos,
  output logic                locked,
  output logic                drop
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t        state;
  logic [GW-1:0] good;
  logic [MW-1:0] miss;
  logic          match;
  logic          at_am;
  logic [PW-1:0] pos_inc;

  assign match   = (am_field == AM_VALUE);
  assign at_am   = (pos == '0);
  assign pos_inc = (pos == PW'(AM_PERIOD - 1)) ? '0 : pos + PW'(1);

  // Lock is lost on this beat; the deskew logic uses this to suppress any alignment update.
  assign drop = valid && (state == LOCKED) && at_am && !match && (miss == MW'(UNLOCK_COUNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SEARCH;
      pos    <= '0;
      good   <= '0;
      miss   <= '0;
      locked <= 1'b0;
    end else if (valid) begin
      case (state)
        SEARCH: begin
          if (match) begin
            pos   <= PW'(1);
            good  <= '0;
            state <= VERIFY;
          end
        end
        VERIFY: begin
          pos <= pos_inc;
          if (at_am) begin
            if (!match) begin
              state <= SEARCH;
              pos   <= '0;
              good  <= '0;
            end else if (good == GW'(LOCK_COUNT - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
              good   <= GW'(LOCK_COUNT);
              miss   <= '0;
            end else begin
              good <= good + GW'(1);
            end
          end
        end
        LOCKED: begin
          pos <= pos_inc;
          if (at_am) begin
            if (match) begin
              miss <= '0;
            end else if (drop) begin
              state  <= SEARCH;
              pos    <= '0;
              good   <= '0;
              miss   <= '0;
              locked <= 1'b0;
            end else begin
              miss <= miss + MW'(1);
            end
          end
        end
        default: begin
          state  <= SEARCH;
          pos    <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end
endmodule

module aui_am_lock #(
  parameter int                  BITS_BLOCK   = 257,
  parameter int                  AM_WIDTH     = 64,
  parameter logic [AM_WIDTH-1:0] AM0_VALUE    = 64'hC168_213E_97DE_6821,
  parameter logic [AM_WIDTH-1:0] AM1_VALUE    = 64'h9C71_8E63_638E_718C,
  parameter int                  AM_PERIOD    = 1024,
  parameter int                  LOCK_COUNT   = 2,
  parameter int                  UNLOCK_COUNT = 3,
  parameter int                  MAX_SKEW     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [BITS_BLOCK-1:0] i_flow_0,
  input  logic [BITS_BLOCK-1:0] i_flow_1,
  output logic                  o_valid,
  output logic [BITS_BLOCK-1:0] o_flow_0,
  output logic [BITS_BLOCK-1:0] o_flow_1,
  output logic                  o_am,
  output logic                  o_lock_0,
  output logic                  o_lock_1,
  output logic                  o_aligned,
  output logic                  o_skew_err
);
  localparam int PW = $clog2(AM_PERIOD);
  localparam int DW = $clog2(MAX_SKEW + 1);
  localparam logic [PW:0] PERIOD_X = (PW + 1)'(AM_PERIOD);
  localparam logic [1:0][AM_WIDTH-1:0] AM_VALUES = {AM1_VALUE, AM0_VALUE};

  logic [1:0][AM_WIDTH-1:0] am_fields;
  logic [1:0][PW-1:0]       pos_w;
  logic [1:0]               locked_w;
  logic [1:0]               drop_w;

  assign am_fields = {i_flow_1[AM_WIDTH-1:0], i_flow_0[AM_WIDTH-1:0]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_flow
    aui_am_lock_fsm #(
      .AM_WIDTH     (AM_WIDTH),
      .AM_VALUE     (AM_VALUES[gi]),
      .AM_PERIOD    (AM_PERIOD),
      .LOCK_COUNT   (LOCK_COUNT),
      .UNLOCK_COUNT (UNLOCK_COUNT),
      .PW           (PW)
    ) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (i_valid),
      .am_field (am_fields[gi]),
      .pos      (pos_w[gi]),
      .locked   (locked_w[gi]),
      .drop     (drop_w[gi])
    );
  end

  assign o_lock_0 = locked_w[0];
  assign o_lock_1 = locked_w[1];

  logic [BITS_BLOCK-1:0] sr0 [MAX_SKEW];
  logic [BITS_BLOCK-1:0] sr1 [MAX_SKEW];
  logic [BITS_BLOCK-1:0] tap0;
  logic [BITS_BLOCK-1:0] tap1;
  logic [DW-1:0]         d0;
  logic [DW-1:0]         d1;
  logic                  aligned;
  logic                  skew_err;
  logic                  both_locked;
  logic                  tap_am;
  logic [PW:0]           back_dist;

  // Tap 0 is the live input; tap k is the block seen k valid beats ago.
  always_comb begin
    tap0 = i_flow_0;
    tap1 = i_flow_1;
    for (int k = 1; k <= MAX_SKEW; k++) begin
      if (d0 == DW'(k)) tap0 = sr0[k-1];
      if (d1 == DW'(k)) tap1 = sr1[k-1];
    end
  end

  assign both_locked = locked_w[0] && locked_w[1] && !drop_w[0] && !drop_w[1];
  assign back_dist   = PERIOD_X - {1'b0, pos_w[1]};
  // The delayed flow-0 block sits d0 positions behind pos0, so its AM shows up at pos0 == d0.
  assign tap_am      = (pos_w[0] == PW'(d0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_SKEW; k++) begin
        sr0[k] <= '0;
        sr1[k] <= '0;
      end
      d0       <= '0;
      d1       <= '0;
      aligned  <= 1'b0;
      skew_err <= 1'b0;
      o_flow_0 <= '0;
      o_flow_1 <= '0;
      o_valid  <= 1'b0;
      o_am     <= 1'b0;
    end else begin
      if (i_valid) begin
        sr0[0] <= i_flow_0;
        sr1[0] <= i_flow_1;
        for (int k = 1; k < MAX_SKEW; k++) begin
          sr0[k] <= sr0[k-1];
          sr1[k] <= sr1[k-1];
        end
        o_flow_0 <= tap0;
        o_flow_1 <= tap1;

        if (!both_locked) begin
          aligned  <= 1'b0;
          skew_err <= 1'b0;
          d0       <= '0;
          d1       <= '0;
        end else if (!aligned && !skew_err && (pos_w[0] == '0)) begin
          if (pos_w[1] <= PW'(MAX_SKEW)) begin
            d1      <= DW'(pos_w[1]);
            d0      <= '0;
            aligned <= 1'b1;
          end else if (back_dist <= (PW + 1)'(MAX_SKEW)) begin
            d0      <= DW'(back_dist);
            d1      <= '0;
            aligned <= 1'b1;
          end else begin
            skew_err <= 1'b1;
          end
        end
      end

`ifdef AUI_AM_STRIP_EN
      o_valid <= i_valid && aligned && !tap_am;
      o_am    <= 1'b0;
`else
      o_valid <= i_valid && aligned;
      o_am    <= i_valid && aligned && tap_am;
`endif
    end
  end

  assign o_aligned  = aligned;
  assign o_skew_err = skew_err;
endmodule

// File: tb/tb_aui_am_lock.sv
// Directed bench for aui_am_lock with AM_PERIOD=16, LOCK_COUNT=2, UNLOCK_COUNT=3, MAX_SKEW=4.
module tb_aui_am_lock;
  localparam int BB = 257;
  localparam int P  = 16;
  localparam logic [63:0] AM0 = 64'hC168_213E_97DE_6821;
  localparam logic [63:0] AM1 = 64'h9C71_8E63_638E_718C;
`ifdef AUI_AM_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [BB-1:0] i_flow_0 = '0;
  logic [BB-1:0] i_flow_1 = '0;
  logic          o_valid;
  logic [BB-1:0] o_flow_0;
  logic [BB-1:0] o_flow_1;
  logic          o_am;
  logic          o_lock_0;
  logic          o_lock_1;
  logic          o_aligned;
  logic          o_skew_err;

  aui_am_lock #(
    .AM_PERIOD    (P),
    .LOCK_COUNT   (2),
    .UNLOCK_COUNT (3),
    .MAX_SKEW     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_flow_0   (i_flow_0),
    .i_flow_1   (i_flow_1),
    .o_valid    (o_valid),
    .o_flow_0   (o_flow_0),
    .o_flow_1   (o_flow_1),
    .o_am       (o_am),
    .o_lock_0   (o_lock_0),
    .o_lock_1   (o_lock_1),
    .o_aligned  (o_aligned),
    .o_skew_err (o_skew_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int b = 0;
  int off0 = 0;
  int off1 = 0;
  int false_beat = -1;
  int vcount = 0;
  int amcount = 0;
  bit bad_en = 1'b0;

  task automatic check(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s", tag);
    end
  endtask

  // Block: {flow id, zeros, beat number, AM pattern or filler}
  function automatic logic [BB-1:0] mk(input int flow, input int beat, input bit am);
    logic [63:0] low;
    logic [63:0] bv;
    bv = 64'(beat);
    if (am) low = (flow == 0) ? AM0 : AM1;
    else    low = {32'h5A5A_0000, bv[31:0]};
    return {(flow == 1), 128'h0, bv, low};
  endfunction

  task automatic do_reset();
    i_valid  = 1'b0;
    i_flow_0 = '0;
    i_flow_1 = '0;
    rst_n    = 1'b0;
    b        = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_beat();
    bit a0;
    bit a1;
    a0 = (b >= off0) && (((b - off0) % P) == 0);
    a1 = (b >= off1) && (((b - off1) % P) == 0);
    if (bad_en && (b == 96 || b == 128 || b == 144 || b == 160)) a0 = 1'b0;
    if (b == false_beat) a0 = 1'b1;
    i_flow_0 = mk(0, b, a0);
    i_flow_1 = mk(1, b, a1);
    i_valid  = 1'b1;
    @(posedge clk);
    #1;
    vcount  += int'(o_valid);
    amcount += int'(o_am);
    b++;
  endtask

  task automatic run_to(input int last);
    while (b <= last) do_beat();
  endtask

  task automatic idle(input int n);
    i_valid  = 1'b0;
    i_flow_0 = mk(0, 0, 1'b1);
    i_flow_1 = mk(1, 0, 1'b1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Zero skew, false AM, gap, single miss, lock loss, relock, async reset
    off0 = 0; off1 = 0; bad_en = 1'b1; false_beat = 69;
    do_reset();
    check("rst_valid",   o_valid,    0);
    check("rst_lock0",   o_lock_0,   0);
    check("rst_lock1",   o_lock_1,   0);
    check("rst_aligned", o_aligned,  0);
    check("rst_skewerr", o_skew_err, 0);
    check("rst_am",      o_am,       0);
    check("rst_flow0",   o_flow_0,   '0);
    run_to(31);
    check("a31_lock0", o_lock_0, 0);
    check("a31_lock1", o_lock_1, 0);
    run_to(32);
    check("a32_lock0", o_lock_0, 1);
    check("a32_lock1", o_lock_1, 1);
    run_to(47);
    check("a47_aligned", o_aligned, 0);
    run_to(48);
    check("a48_aligned", o_aligned, 1);
    check("a48_valid",   o_valid,   0);
    check("a48_skewerr", o_skew_err, 0);
    run_to(49);
    check("a49_valid", o_valid,  1);
    check("a49_flow0", o_flow_0, mk(0, 49, 1'b0));
    check("a49_flow1", o_flow_1, mk(1, 49, 1'b0));
    run_to(64);
    check("a64_am",    o_am,     STRIP ? 0 : 1);
    check("a64_valid", o_valid,  STRIP ? 0 : 1);
    check("a64_flow0", o_flow_0, mk(0, 64, 1'b1));
    check("a64_flow1", o_flow_1, mk(1, 64, 1'b1));
    vcount = 0; amcount = 0;
    run_to(69);
    check("a69_false_am", o_am,     0);
    check("a69_lock0",    o_lock_0, 1);
    run_to(80);
    check("a65_80_valid_cnt", vcount,  STRIP ? 15 : 16);
    check("a65_80_am_cnt",    amcount, STRIP ? 0 : 1);
    idle(5);
    check("gap_valid", o_valid,  0);
    check("gap_lock0", o_lock_0, 1);
    run_to(96);
    check("a96_lock0",   o_lock_0,  1);
    check("a96_aligned", o_aligned, 1);
    run_to(97);
    check("a97_valid", o_valid, 1);
    run_to(112);
    check("a112_am",    o_am,     STRIP ? 0 : 1);
    check("a112_flow0", o_flow_0, mk(0, 112, 1'b1));
    run_to(144);
    check("a144_lock0", o_lock_0, 1);
    run_to(160);
    check("a160_lock0",   o_lock_0,  0);
    check("a160_lock1",   o_lock_1,  1);
    check("a160_aligned", o_aligned, 0);
    run_to(161);
    check("a161_valid", o_valid, 0);
    run_to(207);
    check("a207_lock0", o_lock_0, 0);
    run_to(208);
    check("a208_lock0", o_lock_0, 1);
    run_to(223);
    check("a223_aligned", o_aligned, 0);
    run_to(224);
    check("a224_aligned", o_aligned, 1);
    run_to(240);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",   o_valid,   0);
    check("arst_lock0",   o_lock_0,  0);
    check("arst_lock1",   o_lock_1,  0);
    check("arst_aligned", o_aligned, 0);
    check("arst_flow0",   o_flow_0,  '0);
    #2 rst_n = 1'b1;
    run_to(287);
    check("a287_lock0", o_lock_0, 0);
    run_to(288);
    check("a288_lock0", o_lock_0, 1);
    check("a288_lock1", o_lock_1, 1);
    run_to(303);
    check("a303_aligned", o_aligned, 0);
    run_to(304);
    check("a304_aligned", o_aligned, 1);

    // Flow 1 leads by 3 beats: expect d1=3
    off0 = 16; off1 = 13; bad_en = 1'b0; false_beat = -1;
    do_reset();
    run_to(45);
    check("b45_lock1", o_lock_1, 1);
    check("b45_lock0", o_lock_0, 0);
    run_to(48);
    check("b48_lock0", o_lock_0, 1);
    run_to(63);
    check("b63_aligned", o_aligned, 0);
    run_to(64);
    check("b64_aligned", o_aligned, 1);
    run_to(65);
    check("b65_valid", o_valid,  1);
    check("b65_flow0", o_flow_0, mk(0, 65, 1'b0));
    check("b65_flow1", o_flow_1, mk(1, 62, 1'b0));
    run_to(80);
    check("b80_am",    o_am,     STRIP ? 0 : 1);
    check("b80_flow0", o_flow_0, mk(0, 80, 1'b1));
    check("b80_flow1", o_flow_1, mk(1, 77, 1'b1));

    // Flow 0 leads by 2 beats: expect d0=2
    off0 = 16; off1 = 18;
    do_reset();
    run_to(64);
    check("c64_aligned", o_aligned,  1);
    check("c64_skewerr", o_skew_err, 0);
    run_to(65);
    check("c65_flow0", o_flow_0, mk(0, 63, 1'b0));
    check("c65_flow1", o_flow_1, mk(1, 65, 1'b0));
    run_to(66);
    check("c66_am",    o_am,     STRIP ? 0 : 1);
    check("c66_flow0", o_flow_0, mk(0, 64, 1'b1));
    check("c66_flow1", o_flow_1, mk(1, 66, 1'b1));

    // Offset of 7 blocks exceeds MAX_SKEW
    off0 = 16; off1 = 23;
    do_reset();
    run_to(64);
    check("d64_skewerr", o_skew_err, 1);
    check("d64_aligned", o_aligned,  0);
    vcount = 0;
    run_to(100);
    check("d65_100_valid_cnt", vcount,     0);
    check("d100_skewerr",      o_skew_err, 1);
    check("d100_aligned",      o_aligned,  0);

    i_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aui_am_lock.md
# aui_am_lock

Receive-side alignment-marker lock and deskew for the 1.6T AUI datapath. Takes the two 257-bit flows produced by `aui_generator`, after any lane transport, and works in three steps: finds the periodic alignment marker (AM) in each flow, declares per-flow lock, then removes the inter-flow skew. It emits both flows block-aligned with an AM strobe and sits directly in front of the receive FEC/decoder stage.

## Interface

**Parameters**
- `BITS_BLOCK`, 257: block width per flow.
- `AM_WIDTH`, 64: AM match field, `block[AM_WIDTH-1:0]`.
- `AM0_VALUE`, 64'hC168_213E_97DE_6821: AM pattern for flow 0.
- `AM1_VALUE`, 64'h9C71_8E63_638E_718C: AM pattern for flow 1.
- `AM_PERIOD`, 1024: valid blocks from one AM to the next (≥ 4).
- `LOCK_COUNT`, 2: consecutive on-time AMs needed after the first AM before lock.
- `UNLOCK_COUNT`, 3: consecutive missed AMs that drop lock.
- `MAX_SKEW`, 4: maximum correctable skew, in blocks.

**Ports**
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `i_valid`, in, 1: both input flows carry a block this cycle.
- `i_flow_0`, in, BITS_BLOCK: flow 0 block.
- `i_flow_1`, in, BITS_BLOCK: flow 1 block.
- `o_valid`, out, 1: aligned output block pair valid.
- `o_flow_0`, out, BITS_BLOCK: deskewed flow 0.
- `o_flow_1`, out, BITS_BLOCK: deskewed flow 1.
- `o_am`, out, 1: the output pair is the AM pair.
- `o_lock_0`, out, 1: flow 0 is AM-locked.
- `o_lock_1`, out, 1: flow 1 is AM-locked.
- `o_aligned`, out, 1: skew has been measured and applied.
- `o_skew_err`, out, 1: measured skew exceeds MAX_SKEW (sticky until relock).

## Operation

**Per-flow lock FSM** (identical instance per flow; all state advances only on `i_valid`)
- Position counter `pos`, `$clog2(AM_PERIOD)` bits, wraps AM_PERIOD-1 → 0.
- `SEARCH`: on an AM match, set `pos`=1, clear `good`, go to `VERIFY`.
- `VERIFY`: advance `pos`. At `pos`==0:
  - match → `good`+1; reaching LOCK_COUNT → `LOCKED`.
  - no match → `SEARCH`.
- `LOCKED`: `o_lock_x`=1. At `pos`==0:
  - match → clear `miss`.
  - no match → `miss`+1; reaching UNLOCK_COUNT → `SEARCH`.
- Matches at `pos`≠0 are ignored in both `VERIFY` and `LOCKED`.

**Deskew**
- Each flow feeds a shift register of depth MAX_SKEW that shifts on `i_valid`.
- Per-flow delay selects `d0`/`d1` pick which tap feeds the output; at most one of them is nonzero.
- Skew is measured on the first `i_valid` beat where both flows are locked and `pos0`==0:
  - `pos1`≤MAX_SKEW → `d1`=`pos1`, `d0`=0.
  - `AM_PERIOD-pos1`≤MAX_SKEW → `d0`=`AM_PERIOD-pos1`, `d1`=0.
  - otherwise → set `o_skew_err`, leave `o_aligned` at 0.
- `o_aligned` is set on the measurement beat.
- Losing lock on either flow:
  - clears `o_aligned`, `d0`, `d1`, and `o_skew_err`;
  - re-measurement happens at the next joint lock.

**Output**
- `o_valid` = registered `(i_valid && o_aligned)`.
- `o_am` = the selected flow-0 tap is at its AM position.

## Timing

- Reset values: every output is 0, both FSMs are in `SEARCH`, and all counters, delays and shift registers are 0.
- Reset is asynchronous; reset mid-stream discards all state immediately.
- Latency: 1 clk from `i_valid` to `o_valid`. The leading flow additionally carries its delay, counted in valid beats.
- `o_lock_x` rises 1 clk after the beat of the LOCK_COUNT-th on-time AM, and falls 1 clk after the UNLOCK_COUNT-th miss.
- The first beat with `o_aligned`=1 is the measurement beat.
- `o_valid` is asserted from the following `i_valid` beat onward.
- When a beat is both an expected-AM miss and the unlock point, the unlock takes priority; no alignment update happens on that beat.
- Gaps in `i_valid` freeze all counters and shift registers, with no effect on lock.

## Configuration

- `AUI_AM_STRIP_EN` defined: AM pairs are removed from the output. `o_valid` is 0 on those beats and `o_am` is tied to 0.
- `AUI_AM_STRIP_EN` undefined: AM pairs are forwarded with `o_valid`=1 and `o_am`=1.

## Test plan

All scenarios use AM_PERIOD=16, LOCK_COUNT=2, UNLOCK_COUNT=3, MAX_SKEW=4, and continuous `i_valid` unless stated.

- **Zero skew:** both flows carry AMs at beats 0, 16, 32, 48.
  - `o_lock_0` and `o_lock_1` rise after beat 32.
  - `o_aligned` rises at beat 48.
  - `o_am` pulses every 16 `o_valid` beats, with d0=d1=0.
- **Flow 1 leads by 3:** flow 1 AMs at beats 13, 29, 45; flow 0 AMs at beats 16, 32, 48.
  - Result: d1=3, d0=0.
  - Output AM pairs of both flows coincide; checked against a reference model.
- **Skew error:** flow 1 AM offset of 7 blocks from flow 0.
  - `o_skew_err`=1, `o_aligned` stays 0, `o_valid` stays 0.
- **Lock loss:** from the locked state, corrupt flow 0 AMs at 3 consecutive expected positions.
  - `o_lock_0` falls after the 3rd miss.
  - `o_aligned` clears and `o_valid` stops.
  - A single corrupted AM keeps lock.
- **False AM:** inject the AM0 pattern at `pos`=5 while locked.
  - No effect on `pos`, lock, or `o_am`.
- **Reset and strip mode:**
  - Assert `rst_n`=0 mid-stream → all outputs are 0 asynchronously, and relock takes the full sequence again.
  - With `AUI_AM_STRIP_EN`, `o_valid` counts 15 per 16 input beats.
